// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared mode constants and helpers for the VGA timing generator.
//   - 640x480@60 defaults (25.175 MHz class timing)
//   - 800x600@60 mode set (40 MHz class timing, positive syncs)
//   - vga_total(): line/frame length from display, front porch, sync, back porch
package vga_timing_pkg;

  // 640x480@60
  localparam int VGA_H_DISP   = 640;
  localparam int VGA_H_FPORCH = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BPORCH = 48;
  localparam int VGA_V_DISP   = 480;
  localparam int VGA_V_FPORCH = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BPORCH = 33;
  localparam bit VGA_H_POL    = 1'b0;
  localparam bit VGA_V_POL    = 1'b0;

  // 800x600@60
  localparam int SVGA_H_DISP   = 800;
  localparam int SVGA_H_FPORCH = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BPORCH = 88;
  localparam int SVGA_V_DISP   = 600;
  localparam int SVGA_V_FPORCH = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BPORCH = 23;
  localparam bit SVGA_H_POL    = 1'b1;
  localparam bit SVGA_V_POL    = 1'b1;

  localparam int DEF_CNT_W = 10;

  function automatic int vga_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// vga_axis_timing: one raster axis (horizontal or vertical).
//   clk_i, rst_i : clock, async active-high reset
//   clr          : synchronous return to 0 (generator disabled)
//   adv          : advance one position; wraps TOTAL-1 -> 0
//   cnt          : current position
//   last         : cnt is the final position of the axis
//   carry        : adv while on the last position (advances the next axis)
//   sync         : sync decode of cnt, already at the POL level
//   active       : cnt inside the display region
// Decodes are combinational from cnt; the top registers them.
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int DISP  = VGA_H_DISP,
  parameter int FP    = VGA_H_FPORCH,
  parameter int SYNC  = VGA_H_SYNC,
  parameter int BP    = VGA_H_BPORCH,
  parameter bit POL   = 1'b0,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             carry,
  output logic             sync,
  output logic             active
);

  localparam int TOTAL = vga_total(DISP, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(DISP + FP);
  localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(DISP + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] DISP_C   = CNT_W'(DISP);

  generate
    if (FP <= 0 || SYNC <= 0 || BP <= 0 || DISP <= 0) begin : g_bad_mode
      $error("vga_axis_timing: porch, sync and display widths must be non-zero");
    end
    if (CNT_W < 31 && TOTAL > (1 << CNT_W)) begin : g_bad_width
      $error("vga_axis_timing: CNT_W too narrow for axis total");
    end
  endgenerate

  logic sync_on;

  assign last    = (cnt == LAST_C);
  assign carry   = adv & last;
  assign sync_on = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);
  assign sync    = POL ? sync_on : ~sync_on;
  assign active  = (cnt < DISP_C);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (adv)   cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk_i, rst_i   : clock, async active-high reset
//   en_i           : run enable; low returns everything to (0,0) idle
//   pix_en_i       : pixel strobe; counters and outputs move only when high
//   hsync_o/vsync_o: syncs at H_POL/V_POL asserted level
//   disp_active_o  : pixel inside H_DISP x V_DISP
//   vblank_o       : row >= V_DISP
//   line_start_o   : x == 0;  frame_start_o : (x,y) == (0,0)
//   xcol_o/yrow_o  : current pixel coordinates
// All outputs load from one (h_cnt, v_cnt) snapshot on the same qualified
// edge that advances the counters, so they trail the counters by one pixel
// and are always mutually consistent.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP   = VGA_H_DISP,
  parameter int H_FPORCH = VGA_H_FPORCH,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BPORCH = VGA_H_BPORCH,
  parameter int V_DISP   = VGA_V_DISP,
  parameter int V_FPORCH = VGA_V_FPORCH,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BPORCH = VGA_V_BPORCH,
  parameter bit H_POL    = VGA_H_POL,
  parameter bit V_POL    = VGA_V_POL,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pix_en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             disp_active_o,
  output logic             vblank_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] xcol_o,
  output logic [CNT_W-1:0] yrow_o
);

  logic             qual;
  logic             clr;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, h_carry, h_sync, h_act;
  logic             v_last, v_carry, v_sync, v_act;
  logic             unused_v_flags;

  assign qual = en_i & pix_en_i;
  assign clr  = ~en_i;

  vga_axis_timing #(
    .DISP(H_DISP), .FP(H_FPORCH), .SYNC(H_SYNC), .BP(H_BPORCH),
    .POL(H_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk_i(clk_i), .rst_i(rst_i), .clr(clr), .adv(qual),
    .cnt(h_cnt), .last(h_last), .carry(h_carry), .sync(h_sync), .active(h_act)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_timing #(
    .DISP(V_DISP), .FP(V_FPORCH), .SYNC(V_SYNC), .BP(V_BPORCH),
    .POL(V_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk_i(clk_i), .rst_i(rst_i), .clr(clr), .adv(h_carry),
    .cnt(v_cnt), .last(v_last), .carry(v_carry), .sync(v_sync), .active(v_act)
  );

  assign unused_v_flags = v_last ^ v_carry ^ h_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || !en_i) begin
      hsync_o       <= ~H_POL;
      vsync_o       <= ~V_POL;
      disp_active_o <= 1'b0;
      vblank_o      <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      xcol_o        <= '0;
      yrow_o        <= '0;
    end else if (pix_en_i) begin
      hsync_o       <= h_sync;
      vsync_o       <= v_sync;
      disp_active_o <= h_act & v_act;
      vblank_o      <= ~v_act;
      line_start_o  <= (h_cnt == '0);
      frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
      xcol_o        <= h_cnt;
      yrow_o        <= v_cnt;
    end
  end

endmodule
